// File: rtl/gpio_change_logger.sv
// gpio_change_logger
//
// Purpose:
//   Watches NUM_PORTS GPIO ports (output value and direction) for changes,
//   timestamps each change, and queues the events in a first-word-fall-through
//   FIFO that a debug or UART consumer drains over a valid/ready stream.
//   Each source keeps one pending snapshot. A change that arrives while that
//   source is still pending overwrites the snapshot with the newest values and
//   bumps overflow_cnt. Intermediate values are lost, but the final state
//   always reaches the FIFO.
//
// Ports:
//   clk, rst      single rising-edge clock, asynchronous active-high reset
//   enable        gates change detection and the timestamp counter
//   clear         synchronous flush of FIFO, pending flags, ts and overflow_cnt
//   port_out      pin output values, port i at [i*PORT_W +: PORT_W]
//   port_dir      pin directions, same packing
//   evt_valid     FIFO head valid
//   evt_ready     consumer ready
//   evt_port      source index of the head event (NUM_PORTS = trap event)
//   evt_out       port_out snapshot of the head event
//   evt_dir       port_dir snapshot of the head event
//   evt_ts        timestamp taken when the change was detected
//   overflow_cnt  number of coalesced changes, saturates at 16'hFFFF
//   trap_in       CPU trap flag; present only when TRAP_EVT_EN is defined
//
// Configuration:
//   TRAP_EVT_EN   When defined, a 0->1 edge on trap_in raises a trap event.
//                 The trap event has evt_port = NUM_PORTS, zero out/dir
//                 snapshots, and priority over every port.
//
// Handshake: evt_* present the FIFO head whenever evt_valid is 1, and they
// hold steady until the cycle in which evt_valid & evt_ready pops the head.
// A ready seen while the FIFO is empty has no effect.

module gpio_change_logger #(
    parameter int NUM_PORTS = 3,
    parameter int PORT_W    = 8,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             clear,
    input  logic [NUM_PORTS*PORT_W-1:0]      port_out,
    input  logic [NUM_PORTS*PORT_W-1:0]      port_dir,
    output logic                             evt_valid,
    input  logic                             evt_ready,
    output logic [$clog2(NUM_PORTS+1)-1:0]   evt_port,
    output logic [PORT_W-1:0]                evt_out,
    output logic [PORT_W-1:0]                evt_dir,
    output logic [TS_W-1:0]                  evt_ts,
    output logic [15:0]                      overflow_cnt
`ifdef TRAP_EVT_EN
    ,
    input  logic                             trap_in
`endif
);

    localparam int IDX_W = $clog2(NUM_PORTS + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int TRAP  = NUM_PORTS;   // trap source slot, after the ports

    typedef struct packed {
        logic [IDX_W-1:0]  port;
        logic [PORT_W-1:0] out;
        logic [PORT_W-1:0] dir;
        logic [TS_W-1:0]   ts;
    } evt_t;

    logic [NUM_PORTS*PORT_W-1:0] prev_out_q, prev_out_d;
    logic [NUM_PORTS*PORT_W-1:0] prev_dir_q, prev_dir_d;
    logic [NUM_PORTS:0]          pending_q, pending_d;
    logic [PORT_W-1:0]           snap_out_q [NUM_PORTS];
    logic [PORT_W-1:0]           snap_out_d [NUM_PORTS];
    logic [PORT_W-1:0]           snap_dir_q [NUM_PORTS];
    logic [PORT_W-1:0]           snap_dir_d [NUM_PORTS];
    logic [TS_W-1:0]             snap_ts_q  [NUM_PORTS+1];
    logic [TS_W-1:0]             snap_ts_d  [NUM_PORTS+1];
    logic [TS_W-1:0]             ts_q, ts_d;
    logic [15:0]                 ovf_q, ovf_d;
    logic [AW:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW:0]                 rd_ptr_q, rd_ptr_d;
    evt_t                        mem_q [DEPTH];

    logic [NUM_PORTS:0]          detect;
    logic                        trap_detect;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic                        pop;
    logic                        push;
    logic                        sel_valid;
    logic [IDX_W-1:0]            sel_idx;
    evt_t                        push_entry;
    evt_t                        head;
    logic [4:0]                  coalesce_n;
    logic [16:0]                 ovf_sum;

    // ------------------------------------------------------------------
    // Trap edge detection (optional source)
    // ------------------------------------------------------------------
`ifdef TRAP_EVT_EN
    logic trap_prev_q;
    logic trap_prev_d;

    assign trap_prev_d = trap_in;
    assign trap_detect = enable && !clear && trap_in && !trap_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_prev_q <= 1'b0;
        end else begin
            trap_prev_q <= trap_prev_d;
        end
    end
`else
    assign trap_detect = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Port change detection against the previous-cycle values.
    // The previous-value registers track the pins every cycle, even when
    // enable is low or clear is high, so re-enabling never replays old changes.
    // ------------------------------------------------------------------
    always_comb begin
        detect     = '0;
        prev_out_d = port_out;
        prev_dir_d = port_dir;
        for (int i = 0; i < NUM_PORTS; i++) begin
            detect[i] = enable && !clear &&
                ((port_out[i*PORT_W +: PORT_W] != prev_out_q[i*PORT_W +: PORT_W]) ||
                 (port_dir[i*PORT_W +: PORT_W] != prev_dir_q[i*PORT_W +: PORT_W]));
        end
        detect[TRAP] = trap_detect;
    end

    // ------------------------------------------------------------------
    // FIFO status and arbitration: the trap source has top priority, then
    // the lowest-index pending port. A full FIFO still accepts a push in the
    // same cycle that it is popped.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !fifo_empty && evt_ready;
        sel_valid  = |pending_q;
        sel_idx    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        if (pending_q[TRAP]) begin
            sel_idx = IDX_W'(TRAP);
        end
        push = sel_valid && !clear && (!fifo_full || pop);

        // The trap slot has no out/dir snapshot, so its fields stay zero.
        push_entry      = '0;
        push_entry.port = sel_idx;
        for (int s = 0; s <= NUM_PORTS; s++) begin
            if (sel_idx == IDX_W'(s)) begin
                push_entry.ts = snap_ts_q[s];
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                push_entry.out = snap_out_q[i];
                push_entry.dir = snap_dir_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending snapshots, timestamp, overflow counter, FIFO pointers.
    // The push uses the old snapshot. A detect in that same cycle therefore
    // re-arms pending with fresh data and does not count as a coalesce.
    // ------------------------------------------------------------------
    always_comb begin
        pending_d  = pending_q;
        snap_out_d = snap_out_q;
        snap_dir_d = snap_dir_q;
        snap_ts_d  = snap_ts_q;
        coalesce_n = '0;

        if (push) begin
            for (int s = 0; s <= NUM_PORTS; s++) begin
                if (sel_idx == IDX_W'(s)) begin
                    pending_d[s] = 1'b0;
                end
            end
        end

        for (int i = 0; i < NUM_PORTS; i++) begin
            if (detect[i]) begin
                if (pending_d[i]) begin
                    coalesce_n = coalesce_n + 5'd1;
                end
                pending_d[i]  = 1'b1;
                snap_out_d[i] = port_out[i*PORT_W +: PORT_W];
                snap_dir_d[i] = port_dir[i*PORT_W +: PORT_W];
                snap_ts_d[i]  = ts_q;
            end
        end

        if (detect[TRAP]) begin
            if (pending_d[TRAP]) begin
                coalesce_n = coalesce_n + 5'd1;
            end
            pending_d[TRAP] = 1'b1;
            snap_ts_d[TRAP] = ts_q;
        end

        ovf_sum = {1'b0, ovf_q} + {12'd0, coalesce_n};
        ovf_d   = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];

        ts_d     = enable ? ts_q + 1'b1 : ts_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

        if (clear) begin
            pending_d = '0;
            ts_d      = '0;
            ovf_d     = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_out_q <= '0;
            prev_dir_q <= '0;
            pending_q  <= '0;
            ts_q       <= '0;
            ovf_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                snap_out_q[i] <= '0;
                snap_dir_q[i] <= '0;
            end
            for (int s = 0; s <= NUM_PORTS; s++) begin
                snap_ts_q[s] <= '0;
            end
        end else begin
            prev_out_q <= prev_out_d;
            prev_dir_q <= prev_dir_d;
            pending_q  <= pending_d;
            ts_q       <= ts_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            snap_out_q <= snap_out_d;
            snap_dir_q <= snap_dir_d;
            snap_ts_q  <= snap_ts_d;
        end
    end

    // Event storage needs no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign evt_valid    = !fifo_empty;
    assign evt_port     = evt_valid ? head.port : '0;
    assign evt_out      = evt_valid ? head.out  : '0;
    assign evt_dir      = evt_valid ? head.dir  : '0;
    assign evt_ts       = evt_valid ? head.ts   : '0;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_gpio_change_logger.sv
// Self-checking bench for gpio_change_logger (DEPTH=4 so back-pressure is reachable).
module tb_gpio_change_logger;

    localparam int NP    = 3;
    localparam int PW    = 8;
    localparam int DEPTH = 4;
    localparam int TSW   = 32;
    localparam int IW    = $clog2(NP + 1);
    localparam int EW    = IW + 2*PW + TSW;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              clear;
    logic [NP*PW-1:0]  port_out;
    logic [NP*PW-1:0]  port_dir;
    logic              evt_valid;
    logic              evt_ready;
    logic [IW-1:0]     evt_port;
    logic [PW-1:0]     evt_out;
    logic [PW-1:0]     evt_dir;
    logic [TSW-1:0]    evt_ts;
    logic [15:0]       overflow_cnt;
`ifdef TRAP_EVT_EN
    logic              trap_in = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gpio_change_logger #(
        .NUM_PORTS (NP),
        .PORT_W    (PW),
        .DEPTH     (DEPTH),
        .TS_W      (TSW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .port_out     (port_out),
        .port_dir     (port_dir),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_port     (evt_port),
        .evt_out      (evt_out),
        .evt_dir      (evt_dir),
        .evt_ts       (evt_ts),
        .overflow_cnt (overflow_cnt)
`ifdef TRAP_EVT_EN
        ,
        .trap_in      (trap_in)
`endif
    );

    // ------------------------------------------------------------------
    // Reference model: one pending snapshot per port, a bounded queue of
    // expected events, and a coalesce counter.
    // ------------------------------------------------------------------
    logic [PW-1:0]  m_prev_out [NP];
    logic [PW-1:0]  m_prev_dir [NP];
    logic [PW-1:0]  m_snap_out [NP];
    logic [PW-1:0]  m_snap_dir [NP];
    logic [TSW-1:0] m_snap_ts  [NP];
    bit             m_pend     [NP];
    logic [TSW-1:0] m_ts;
    int             m_ovf;
    logic [EW-1:0]  exp_q[$];

    always @(posedge clk or posedge rst) begin : model
        int  winner;
        bit  popped;
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                m_prev_out[i] = '0;
                m_prev_dir[i] = '0;
                m_snap_out[i] = '0;
                m_snap_dir[i] = '0;
                m_snap_ts[i]  = '0;
                m_pend[i]     = 1'b0;
            end
            m_ts  = '0;
            m_ovf = 0;
            exp_q.delete();
        end else begin
            if (clear) begin
                exp_q.delete();
                for (int i = 0; i < NP; i++) m_pend[i] = 1'b0;
                m_ts  = '0;
                m_ovf = 0;
            end else begin
                popped = (exp_q.size() > 0) && evt_ready;
                if (popped) void'(exp_q.pop_front());
                winner = -1;
                for (int i = NP - 1; i >= 0; i--) if (m_pend[i]) winner = i;
                if (winner >= 0 && exp_q.size() < DEPTH) begin
                    exp_q.push_back({IW'(winner), m_snap_out[winner],
                                     m_snap_dir[winner], m_snap_ts[winner]});
                    m_pend[winner] = 1'b0;
                end
                for (int i = 0; i < NP; i++) begin
                    if (enable && (port_out[i*PW +: PW] != m_prev_out[i] ||
                                   port_dir[i*PW +: PW] != m_prev_dir[i])) begin
                        if (m_pend[i]) m_ovf = (m_ovf < 65535) ? m_ovf + 1 : 65535;
                        m_pend[i]     = 1'b1;
                        m_snap_out[i] = port_out[i*PW +: PW];
                        m_snap_dir[i] = port_dir[i*PW +: PW];
                        m_snap_ts[i]  = m_ts;
                    end
                end
                if (enable) m_ts = m_ts + 1'b1;
            end
            for (int i = 0; i < NP; i++) begin
                m_prev_out[i] = port_out[i*PW +: PW];
                m_prev_dir[i] = port_dir[i*PW +: PW];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; clear = 1'b0; evt_ready = 1'b0;
        port_out = '0; port_dir = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", evt_valid); else n_pass++;
        n_checks++; if (evt_port !== '0) $display("FAIL reset_port: got %0d want 0", evt_port); else n_pass++;
        n_checks++; if (evt_out !== '0) $display("FAIL reset_out: got %h want 00", evt_out); else n_pass++;
        n_checks++; if (evt_dir !== '0) $display("FAIL reset_dir: got %h want 00", evt_dir); else n_pass++;
        n_checks++; if (evt_ts !== '0) $display("FAIL reset_ts: got %0d want 0", evt_ts); else n_pass++;
        n_checks++; if (overflow_cnt !== 16'd0) $display("FAIL reset_ovf: got %0d want 0", overflow_cnt); else n_pass++;
        rst = 1'b0; enable = 1'b1; evt_ready = 1'b1;
        tick(); tick();
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL idle_after_reset: got %0b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_single_change();
        clear = 1'b1; tick(); clear = 1'b0;
        repeat (5) tick();                 // ts now 5
        port_out[7:0] = 8'h01;
        tick();
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL single_early: valid %0b want 0", evt_valid); else n_pass++;
        tick();
        n_checks++; if (evt_valid !== 1'b1) $display("FAIL single_valid: got %0b want 1", evt_valid); else n_pass++;
        n_checks++; if ({evt_port, evt_out, evt_dir, evt_ts} !== {2'd0, 8'h01, 8'h00, 32'd5})
            $display("FAIL single_evt: got port %0d out %h dir %h ts %0d want 0/01/00/5", evt_port, evt_out, evt_dir, evt_ts);
        else n_pass++;
        tick();
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL single_one_cycle: valid %0b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_two_ports();
        logic [TSW-1:0] exp_ts;
        exp_ts = m_ts;
        port_out[7:0]   = 8'h55;
        port_out[23:16] = 8'hAA;
        tick(); tick();
        n_checks++; if ({evt_valid, evt_port, evt_out, evt_ts} !== {1'b1, 2'd0, 8'h55, exp_ts})
            $display("FAIL two_first: got v %0b port %0d out %h ts %0d want 1/0/55/%0d", evt_valid, evt_port, evt_out, evt_ts, exp_ts);
        else n_pass++;
        tick();
        n_checks++; if ({evt_valid, evt_port, evt_out, evt_ts} !== {1'b1, 2'd2, 8'hAA, exp_ts})
            $display("FAIL two_second: got v %0b port %0d out %h ts %0d want 1/2/AA/%0d", evt_valid, evt_port, evt_out, evt_ts, exp_ts);
        else n_pass++;
        tick();
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL two_drained: valid %0b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_backpressure_coalesce();
        logic [PW-1:0] exp_out [5];
        exp_out = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        clear = 1'b1; tick(); clear = 1'b0;
        evt_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            port_out[15:8] = PW'(v);
            tick();
        end
        tick(); tick();
        n_checks++; if (overflow_cnt !== 16'd1) $display("FAIL bp_ovf: got %0d want 1", overflow_cnt); else n_pass++;
        n_checks++; if ({evt_valid, evt_out} !== {1'b1, 8'h01}) $display("FAIL bp_head_stall: got v %0b out %h want 1/01", evt_valid, evt_out); else n_pass++;
        evt_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if ({evt_valid, evt_port, evt_out} !== {1'b1, 2'd1, exp_out[k]})
                $display("FAIL bp_drain%0d: got v %0b port %0d out %h want 1/1/%h", k, evt_valid, evt_port, evt_out, exp_out[k]);
            else n_pass++;
            tick();
        end
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL bp_empty: valid %0b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_dir_only();
        logic [TSW-1:0] exp_ts;
        exp_ts = m_ts;
        port_dir[23:16] = 8'hFF;
        tick(); tick();
        n_checks++; if ({evt_valid, evt_port, evt_out, evt_dir, evt_ts} !== {1'b1, 2'd2, 8'hAA, 8'hFF, exp_ts})
            $display("FAIL dir_only: got v %0b port %0d out %h dir %h ts %0d want 1/2/AA/FF/%0d", evt_valid, evt_port, evt_out, evt_dir, evt_ts, exp_ts);
        else n_pass++;
        tick();
    endtask

    task automatic test_clear();
        clear = 1'b1; tick(); clear = 1'b0;
        evt_ready = 1'b0;
        port_out = {8'h33, 8'h22, 8'h11};
        tick();
        port_out[23:16] = 8'h34;           // port2 still pending -> coalesce
        repeat (4) tick();
        n_checks++; if ({evt_valid, overflow_cnt} !== {1'b1, 16'd1}) $display("FAIL clr_before: got v %0b ovf %0d want 1/1", evt_valid, overflow_cnt); else n_pass++;
        clear = 1'b1;
        port_out[7:0] = 8'h99;             // swallowed: prev regs track during clear
        tick();
        clear = 1'b0;
        n_checks++; if ({evt_valid, overflow_cnt} !== {1'b0, 16'd0}) $display("FAIL clr_after: got v %0b ovf %0d want 0/0", evt_valid, overflow_cnt); else n_pass++;
        port_out[15:8] = 8'h44;
        tick(); tick();
        n_checks++; if ({evt_valid, evt_port, evt_out, evt_ts} !== {1'b1, 2'd1, 8'h44, 32'd0})
            $display("FAIL clr_ts: got v %0b port %0d out %h ts %0d want 1/1/44/0", evt_valid, evt_port, evt_out, evt_ts);
        else n_pass++;
        evt_ready = 1'b1;
        tick();
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL clr_no_port0: valid %0b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_enable_off();
        enable = 1'b0; evt_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            port_out = NP*PW'($urandom);
            port_dir = NP*PW'($urandom);
            tick();
            n_checks++; if (evt_valid !== 1'b0) $display("FAIL en_off%0d: valid %0b want 0", n, evt_valid); else n_pass++;
        end
        enable = 1'b1;
        repeat (3) tick();
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL en_reenable: valid %0b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_random();
        int ready_bias;
        ready_bias = 3;
        for (int c = 0; c < 1500; c++) begin
            if (c % 200 == 0) ready_bias = $urandom_range(0, 4);
            n_checks++; if (evt_valid !== (exp_q.size() != 0))
                $display("FAIL rnd_valid c%0d: got %0b want %0b", c, evt_valid, exp_q.size() != 0);
            else n_pass++;
            if (exp_q.size() != 0) begin
                n_checks++; if ({evt_port, evt_out, evt_dir, evt_ts} !== exp_q[0])
                    $display("FAIL rnd_head c%0d: got %h want %h", c, {evt_port, evt_out, evt_dir, evt_ts}, exp_q[0]);
                else n_pass++;
            end
            n_checks++; if (overflow_cnt !== 16'(m_ovf))
                $display("FAIL rnd_ovf c%0d: got %0d want %0d", c, overflow_cnt, m_ovf);
            else n_pass++;
            enable    = ($urandom_range(0, 7) != 0);
            clear     = ($urandom_range(0, 99) == 0);
            evt_ready = ($urandom_range(0, 3) < ready_bias);
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 3) == 0) port_out[i*PW +: PW] = PW'($urandom);
                if ($urandom_range(0, 7) == 0) port_dir[i*PW +: PW] = PW'($urandom);
            end
            tick();
        end
        clear = 1'b0; enable = 1'b1;
    endtask

    task automatic test_async_reset();
        evt_ready = 1'b0;
        port_out  = {8'h3C, 8'h2B, 8'h1A};
        port_dir  = '0;
        repeat (4) tick();
        n_checks++; if (evt_valid !== (exp_q.size() != 0)) $display("FAIL ar_pre: valid %0b want %0b", evt_valid, exp_q.size() != 0); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({evt_valid, overflow_cnt, evt_ts} !== {1'b0, 16'd0, 32'd0})
            $display("FAIL ar_immediate: got v %0b ovf %0d ts %0d want 0/0/0", evt_valid, overflow_cnt, evt_ts);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; evt_ready = 1'b1;
        tick(); tick();
        n_checks++; if ({evt_valid, evt_port, evt_out, evt_ts} !== {1'b1, 2'd0, 8'h1A, 32'd0})
            $display("FAIL ar_evt0: got v %0b port %0d out %h ts %0d want 1/0/1A/0", evt_valid, evt_port, evt_out, evt_ts);
        else n_pass++;
        tick();
        n_checks++; if ({evt_valid, evt_port, evt_out} !== {1'b1, 2'd1, 8'h2B})
            $display("FAIL ar_evt1: got v %0b port %0d out %h want 1/1/2B", evt_valid, evt_port, evt_out);
        else n_pass++;
        tick();
        n_checks++; if ({evt_valid, evt_port, evt_out} !== {1'b1, 2'd2, 8'h3C})
            $display("FAIL ar_evt2: got v %0b port %0d out %h want 1/2/3C", evt_valid, evt_port, evt_out);
        else n_pass++;
        tick();
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL ar_done: valid %0b want 0", evt_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_change();
        test_two_ports();
        test_backpressure_coalesce();
        test_dir_only();
        test_clear();
        test_enable_off();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
